// File: rtl/fifo_byte_serializer.sv
// Drains the upstream word FIFO one word at a time and streams each word out
// as DATA_WIDTH/8 bytes over a valid/ready handshake, counting completed words.
module fifo_byte_serializer #(
   parameter int DATA_WIDTH = 32,
   parameter bit MSB_FIRST  = 1'b0,
   parameter int COUNT_W    = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  fifo_empty,
   output logic                  fifo_pop,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic [7:0]            byte_out,
   output logic                  byte_valid,
   input  logic                  byte_ready,
   output logic                  last_byte,
   output logic                  busy,
   output logic [COUNT_W-1:0]    word_count
);
   localparam int NBYTES = DATA_WIDTH / 8;
   localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

   typedef enum logic [1:0] {IDLE, POP, LOAD, SEND} state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [COUNT_W-1:0]    count_q, count_d;
   logic                  xfer;
   logic                  can_pop;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         shift_q <= '0;
         idx_q   <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      idx_d   = idx_q;
      count_d = count_q;
      xfer    = (state_q == SEND) && byte_ready;
      can_pop = enable && !fifo_empty;
      case (state_q)
         IDLE: if (can_pop) state_d = POP;
         POP:  state_d = LOAD;
         // FIFO output is valid here, one cycle after the pop edge
         LOAD: begin
            shift_d = fifo_data;
            idx_d   = '0;
            state_d = SEND;
         end
         SEND: begin
            if (xfer) begin
               idx_d   = idx_q + IDX_W'(1);
               shift_d = MSB_FIRST ? (shift_q << 8) : (shift_q >> 8);
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  count_d = count_q + COUNT_W'(1);
                  state_d = can_pop ? POP : IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // The outgoing byte always sits at one end of the shift register.
   assign byte_out   = MSB_FIRST ? shift_q[DATA_WIDTH-1 -: 8] : shift_q[7:0];
   assign fifo_pop   = (state_q == POP);
   assign byte_valid = (state_q == SEND);
   assign busy       = (state_q != IDLE);
   assign last_byte  = (state_q == SEND) && (idx_q == LAST_IDX);
   assign word_count = count_q;

endmodule
